// File: rtl/e_calc_pkg.sv
// Shared constants and state type for the e_calc result streamer.
package e_calc_pkg;

   localparam int unsigned WORD_W = 16;

   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] ASCII_DOT = 8'h2E;
   localparam logic [7:0] ASCII_NL  = 8'h0A;
   localparam logic [7:0] ASCII_Q   = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      S_INT,
      S_DOT,
      MUL,
      S_DIG,
      S_NL,
      FIN
   } streamer_state_t;

endpackage

// File: rtl/mp_mul10_step.sv
// One limb of a multi-word multiply-by-ten: {carry_out, w_out} = w*10 + carry_in.
module mp_mul10_step
   import e_calc_pkg::*;
(
   input  logic [WORD_W-1:0] w,
   input  logic [3:0]        carry_in,
   output logic [WORD_W-1:0] w_out,
   output logic [3:0]        carry_out
);

   localparam int unsigned P_W = WORD_W + 4;

   logic [P_W-1:0] p;

   // Max 65535*10 + 9 fits in 20 bits, so the carry is always 0..9.
   always_comb begin
      p         = P_W'(w) * P_W'(10) + P_W'(carry_in);
      w_out     = p[WORD_W-1:0];
      carry_out = p[P_W-1:WORD_W];
   end

endmodule

// File: rtl/e_digit_streamer.sv
// Snapshots the fixed-point e_calc result and streams it as decimal ASCII "I.ddd...d\n".
module e_digit_streamer
   import e_calc_pkg::*;
#(
   parameter int unsigned WORDS   = 32,
   parameter int unsigned NDIGITS = 100
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] result [0:WORDS-1],
   output logic              busy,
   output logic              done,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam int unsigned FRAC_WORDS = WORDS - 1;
   localparam int unsigned IDX_W      = (FRAC_WORDS > 1) ? $clog2(FRAC_WORDS) : 1;
   localparam int unsigned CNT_W      = $clog2(NDIGITS + 1);

   streamer_state_t   state;
   logic [WORD_W-1:0] snap [0:FRAC_WORDS-1];
   logic [IDX_W-1:0]  idx;
   logic [3:0]        carry;
   logic [CNT_W-1:0]  dcnt;
   logic [WORD_W-1:0] mul_w;
   logic [3:0]        mul_c;

   // Single shared x10 limb, walked LSW to MSW across the fraction snapshot.
   mp_mul10_step u_mul (
      .w         (snap[idx]),
      .carry_in  (carry),
      .w_out     (mul_w),
      .carry_out (mul_c)
   );

   // Control FSM; every output is a register updated on state transitions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         idx      <= '0;
         carry    <= '0;
         dcnt     <= '0;
         for (int i = 0; i < int'(FRAC_WORDS); i++) snap[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               for (int i = 0; i < int'(FRAC_WORDS); i++) snap[i] <= result[i];
               // Integer digit is latched into tx_data now, so it is also isolated from later changes.
               tx_data  <= (result[WORDS-1] <= WORD_W'(9)) ?
                           ASCII_0 + 8'(result[WORDS-1][3:0]) : ASCII_Q;
               tx_valid <= 1'b1;
               idx      <= '0;
               carry    <= '0;
               dcnt     <= '0;
               state    <= S_INT;
            end
            S_INT: begin
               if (tx_ready) begin
                  tx_data <= ASCII_DOT;
                  state   <= S_DOT;
               end
            end
            S_DOT: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= MUL;
               end
            end
            MUL: begin
               snap[idx] <= mul_w;
               if (idx == IDX_W'(FRAC_WORDS - 1)) begin
                  idx      <= '0;
                  carry    <= '0;
                  dcnt     <= dcnt + CNT_W'(1);
                  tx_data  <= ASCII_0 + 8'(mul_c);
                  tx_valid <= 1'b1;
                  state    <= S_DIG;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  carry <= mul_c;
               end
            end
            S_DIG: begin
               if (tx_ready) begin
                  if (dcnt == CNT_W'(NDIGITS)) begin
                     tx_data <= ASCII_NL;
                     state   <= S_NL;
                  end else begin
                     tx_valid <= 1'b0;
                     state    <= MUL;
                  end
               end
            end
            S_NL: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_e_digit_streamer.sv
// Self-checking bench for e_digit_streamer: table vectors, random results/backpressure, reset and snapshot corners.
module tb_e_digit_streamer;

   localparam int unsigned WORDS   = 32;
   localparam int unsigned NDIGITS = 100;
   localparam int unsigned FW      = (WORDS - 1) * 16;
   localparam int          BUDGET  = 20000;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] result [0:WORDS-1];
   logic        busy;
   logic        done;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int          vectors;
   int          miscompares;
   logic [7:0]  cap_q[$];
   logic [7:0]  exp_q[$];
   int          done_cnt;
   bit          rdy_random;
   bit          prev_hold;
   logic [7:0]  prev_data;

   e_digit_streamer #(.WORDS(WORDS), .NDIGITS(NDIGITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .result   (result),
      .busy     (busy),
      .done     (done),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sink readiness: always-ready or ~30% random, changed just after each rising edge.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = rdy_random ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   end

   // Byte capture, done counting and stall-stability checking on the falling edge.
   initial begin
      prev_hold = 1'b0;
      prev_data = 8'h00;
      done_cnt  = 0;
      forever begin
         @(negedge clk);
         if (prev_hold) begin
            vectors++;
            if (!tx_valid || tx_data !== prev_data) begin
               miscompares++;
               $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h",
                        tx_valid, tx_data, prev_data);
            end
         end
         prev_hold = tx_valid && !tx_ready && rst_n;
         prev_data = tx_data;
         if (tx_valid && tx_ready && rst_n) cap_q.push_back(tx_data);
         if (done) done_cnt++;
      end
   end

   task automatic check(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Reference: the fraction is one wide integer; each digit is the overflow of fraction*10.
   task automatic build_expected();
      logic [FW-1:0] f;
      logic [FW+3:0] p;
      exp_q.delete();
      for (int i = 0; i < int'(WORDS) - 1; i++) f[i*16 +: 16] = result[i];
      exp_q.push_back((result[WORDS-1] <= 16'd9) ? 8'h30 + 8'(result[WORDS-1]) : 8'h3F);
      exp_q.push_back(8'h2E);
      for (int d = 0; d < int'(NDIGITS); d++) begin
         p = {4'b0, f} * (FW+4)'(10);
         exp_q.push_back(8'h30 + 8'(p[FW+3:FW]));
         f = p[FW-1:0];
      end
      exp_q.push_back(8'h0A);
   endtask

   task automatic check_stream(input string nm);
      int bad;
      bad = -1;
      check({nm, "_len"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
         if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL %s_bytes: byte %0d got %02h required %02h", nm, bad, cap_q[bad], exp_q[bad]);
      end
   endtask

   task automatic set_e();
      logic [15:0] ew [0:15];
      ew = '{16'hB7E1, 16'h5162, 16'h8AED, 16'h2A6A, 16'hBF71, 16'h5880, 16'h9CF4, 16'hF3C7,
             16'h62E7, 16'h160F, 16'h38B4, 16'hDA56, 16'hA784, 16'hD904, 16'h5190, 16'hCFEF};
      for (int i = 0; i < int'(WORDS); i++) result[i] = 16'h0000;
      result[WORDS-1] = 16'h0002;
      for (int i = 0; i < 16; i++) result[WORDS-2-i] = ew[i];
   endtask

   task automatic randomize_result();
      for (int i = 0; i < int'(WORDS) - 1; i++) result[i] = 16'($urandom);
      result[WORDS-1] = 16'($urandom_range(0, 15));
   endtask

   // One conversion: pulse start, wait (bounded) for done, then compare the captured stream.
   task automatic run_case(input string nm, input bit rmode, input bit poke, input bit mutate,
                           input bit timing);
      int   fin_cyc;
      int   first_v;
      logic busy1;
      rdy_random = rmode;
      @(posedge clk);
      #1;
      cap_q.delete();
      done_cnt = 0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      fin_cyc = 0;
      first_v = 0;
      busy1   = 1'b0;
      for (int cyc = 1; cyc <= BUDGET; cyc++) begin
         @(negedge clk);
         if (cyc == 1) busy1 = busy;
         if (first_v == 0 && tx_valid) first_v = cyc;
         if (poke) start = (cyc == 20 || cyc == 300 || cyc == 1500);
         if (mutate && cyc == 4) randomize_result();
         if (done) begin
            fin_cyc = cyc;
            break;
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (fin_cyc == 0) begin
         miscompares++;
         $display("FAIL %s_timeout: no done within %0d cycles, required done", nm, BUDGET);
      end
      check_stream(nm);
      check({nm, "_done_pulses"}, done_cnt, 1);
      check({nm, "_busy_after"}, busy, 0);
      if (timing) begin
         check({nm, "_busy_cycle1"}, busy1, 1);
         check({nm, "_first_valid_cycle"}, first_v, 2);
         check({nm, "_done_cycle"}, fin_cyc, NDIGITS * WORDS + 5);
      end
      rdy_random = 1'b0;
   endtask

   typedef struct {
      string       nm;
      logic [15:0] int_w;
      logic [15:0] msw;
      logic [7:0]  b0;
      logic [7:0]  b2;
      logic [7:0]  b3;
   } vec_t;

   initial begin
      vec_t        tbl [6];
      string       e40;
      int          n;
      logic [7:0]  ch;

      vectors     = 0;
      miscompares = 0;
      rdy_random  = 1'b0;
      rst_n       = 1'b0;
      start       = 1'b0;
      for (int i = 0; i < int'(WORDS); i++) result[i] = 16'h0000;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // Reset wins over a simultaneous start
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_vs_start_busy", busy, 0);
      check("rst_vs_start_valid", tx_valid, 0);

      // e with an always-ready sink, including latency and total cycle count
      set_e();
      build_expected();
      run_case("e_ready", 1'b0, 1'b0, 1'b0, 1'b1);
      e40 = "7182818284590452353602874713526624977572";
      check("e_int_digit", cap_q[0], 8'h32);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         ch = e40[i];
         if (cap_q.size() > i + 2 && cap_q[i+2] !== ch && n == 0) n = i + 1;
      end
      check("e_first40_bad_pos", n, 0);

      // Table of simple fixed-point values with hand-derived leading bytes
      tbl[0] = '{"zero",     16'h0000, 16'h0000, 8'h30, 8'h30, 8'h30};
      tbl[1] = '{"one_half", 16'h0001, 16'h8000, 8'h31, 8'h35, 8'h30};
      tbl[2] = '{"twelve",   16'h000C, 16'h8000, 8'h3F, 8'h35, 8'h30};
      tbl[3] = '{"nine_q",   16'h0009, 16'h4000, 8'h39, 8'h32, 8'h35};
      tbl[4] = '{"three_tq", 16'h0003, 16'hC000, 8'h33, 8'h37, 8'h35};
      tbl[5] = '{"ten",      16'h000A, 16'h0000, 8'h3F, 8'h30, 8'h30};
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < int'(WORDS); i++) result[i] = 16'h0000;
         result[WORDS-1] = tbl[t].int_w;
         result[WORDS-2] = tbl[t].msw;
         build_expected();
         run_case(tbl[t].nm, 1'b0, 1'b0, 1'b0, 1'b0);
         check({tbl[t].nm, "_b0"}, cap_q[0], tbl[t].b0);
         check({tbl[t].nm, "_b1"}, cap_q[1], 8'h2E);
         check({tbl[t].nm, "_b2"}, cap_q[2], tbl[t].b2);
         check({tbl[t].nm, "_b3"}, cap_q[3], tbl[t].b3);
         check({tbl[t].nm, "_last"}, cap_q[cap_q.size()-1], 8'h0A);
      end

      // e under random backpressure, with start pulses while busy
      set_e();
      build_expected();
      run_case("e_backpressure", 1'b1, 1'b1, 1'b0, 1'b0);

      // Reset after the 10th byte, then a fresh run from the top
      rdy_random = 1'b0;
      set_e();
      @(posedge clk);
      #1;
      cap_q.delete();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (cap_q.size() < 10 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("mid_reset_reached_10", (cap_q.size() >= 10) ? 1 : 0, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_reset_valid", tx_valid, 0);
      check("mid_reset_busy", busy, 0);
      check("mid_reset_data", tx_data, 0);
      rst_n = 1'b1;
      build_expected();
      run_case("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("after_reset_first", cap_q[0], 8'h32);

      // Random results, one with inputs changed after the snapshot
      for (int r = 0; r < 3; r++) begin
         randomize_result();
         build_expected();
         run_case((r == 2) ? "rand_mutate" : "rand", 1'(r != 0), 1'b0, 1'(r == 2), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
